// File: rtl/mixer_pkg.sv
// Shared types and helpers for the layer mixer: 4:4:4 and 8:8:8 colour
// structs, fade FSM states and the nibble-to-byte colour expansion.
package mixer_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } colr12_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {
    ST_BRIGHT   = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_DARK     = 2'd2,
    ST_FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [4:0] L_MAX = 5'd16;

  // Replicating the nibble gives c*17, so 4'hF maps to full-scale 8'hFF.
  function automatic logic [7:0] expand4to8(input logic [3:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/fade_ctrl.sv
// Global fade controller: brightness level 0..16 stepped once every
// FADE_FRAMES frame pulses while a fade is in progress.
module fade_ctrl
  import mixer_pkg::*;
#(
  parameter int FADE_FRAMES = 2
) (
  input  logic       i_clk_25,
  input  logic       i_rst_n,
  input  logic       i_frame,
  input  logic       i_fade_out_req,
  input  logic       i_fade_in_req,
  output logic [4:0] o_level,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  fade_state_t      state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [4:0]       level_dn, level_up;

  assign level_dn = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
  assign level_up = (level_q >= L_MAX) ? L_MAX : level_q + 5'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_BRIGHT: if (i_fade_out_req) begin
        state_d = ST_FADE_OUT;
        cnt_d   = '0;
      end
      ST_DARK: if (i_fade_in_req && !i_fade_out_req) begin
        state_d = ST_FADE_IN;
        cnt_d   = '0;
      end
      ST_FADE_OUT: begin
        if (i_fade_in_req && !i_fade_out_req) begin
          state_d = ST_FADE_IN;
          cnt_d   = '0;
        end else if (i_frame) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = level_dn;
            if (level_dn == 5'd0) begin
              state_d = ST_DARK;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FADE_IN: begin
        if (i_fade_out_req) begin
          state_d = ST_FADE_OUT;
          cnt_d   = '0;
        end else if (i_frame) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = level_up;
            if (level_up == L_MAX) begin
              state_d = ST_BRIGHT;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_BRIGHT;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_BRIGHT;
      level_q <= L_MAX;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign o_level = level_q;
  assign o_busy  = (state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN);
  assign o_done  = done_q;

endmodule

// File: rtl/layer_mixer.sv
// Final pixel stage: sprite layer priority/transparency, background fill,
// global fade and sync delay so RGB, syncs and blank leave aligned.
module layer_mixer
  import mixer_pkg::*;
#(
  parameter int          LAYERS      = 4,
  parameter logic [3:0]  TRANS_IDX   = 4'd0,
  parameter int          SYNC_DLY    = 2,
  parameter int          FADE_FRAMES = 2,
  parameter logic [11:0] BG_COLR     = 12'h000
) (
  input  logic                 i_clk_25,
  input  logic                 i_rst_n,
  input  logic [LAYERS-1:0]    i_lyr_drawing,
  input  logic [4*LAYERS-1:0]  i_lyr_pix,
  input  logic [12*LAYERS-1:0] i_lyr_colr,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic                 i_de,
  input  logic                 i_frame,
  input  logic                 i_fade_out_req,
  input  logic                 i_fade_in_req,
  output logic [7:0]           o_r,
  output logic [7:0]           o_g,
  output logic [7:0]           o_b,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_blank_n,
  output logic                 o_fade_busy,
  output logic                 o_fade_done
);

  localparam int DLY = SYNC_DLY + 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  logic [4:0] level;
  colr12_t    win_q, win_d;
  rgb24_t     rgb_q, rgb_d;
  sync_t      sync_q [DLY];
  sync_t      sync_d [DLY];

  fade_ctrl #(.FADE_FRAMES(FADE_FRAMES)) u_fade (
    .i_clk_25       (i_clk_25),
    .i_rst_n        (i_rst_n),
    .i_frame        (i_frame),
    .i_fade_out_req (i_fade_out_req),
    .i_fade_in_req  (i_fade_in_req),
    .o_level        (level),
    .o_busy         (o_fade_busy),
    .o_done         (o_fade_done)
  );

  function automatic logic [7:0] scale8(input logic [7:0] c8, input logic [4:0] lvl);
    logic [12:0] prod;
    prod = 13'(c8) * 13'(lvl);
    if (lvl >= L_MAX) return c8;
    return prod[11:4];
  endfunction

  // Walk from lowest to highest priority so the lowest-index opaque layer lands last.
  always_comb begin
    win_d = colr12_t'(BG_COLR);
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (i_lyr_drawing[k] && (i_lyr_pix[4*k +: 4] != TRANS_IDX))
        win_d = colr12_t'(i_lyr_colr[12*k +: 12]);
    end
  end

  // Colour lags timing by SYNC_DLY, so the tap one stage before the output
  // lines up with the winner held in stage 1.
  always_comb begin
    rgb_d = '0;
    if (sync_q[DLY-2].de) begin
      rgb_d.r = scale8(expand4to8(win_q.r), level);
      rgb_d.g = scale8(expand4to8(win_q.g), level);
      rgb_d.b = scale8(expand4to8(win_q.b), level);
    end
  end

  always_comb begin
    sync_d[0] = '{hs: i_hsync, vs: i_vsync, de: i_de};
    for (int i = 1; i < DLY; i++) sync_d[i] = sync_q[i-1];
  end

  // NOTE: the delay line is a handful of flops, not a RAM, so it takes a reset
  // value (syncs idle high, de low) like any other register.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q <= '0;
      rgb_q <= '0;
      for (int i = 0; i < DLY; i++) sync_q[i] <= '{hs: 1'b1, vs: 1'b1, de: 1'b0};
    end else begin
      win_q <= win_d;
      rgb_q <= rgb_d;
      for (int i = 0; i < DLY; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign o_r       = rgb_q.r;
  assign o_g       = rgb_q.g;
  assign o_b       = rgb_q.b;
  assign o_hsync   = sync_q[DLY-1].hs;
  assign o_vsync   = sync_q[DLY-1].vs;
  assign o_blank_n = sync_q[DLY-1].de;

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: priority, latency, sync alignment, blank,
// and the fade FSM including reset mid-fade.
module tb_layer_mixer;

  logic        i_clk_25 = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_lyr_drawing;
  logic [15:0] i_lyr_pix;
  logic [47:0] i_lyr_colr;
  logic        i_hsync, i_vsync, i_de, i_frame;
  logic        i_fade_out_req, i_fade_in_req;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hsync, o_vsync, o_blank_n, o_fade_busy, o_fade_done;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  always #20 i_clk_25 = ~i_clk_25;

  layer_mixer dut (
    .i_clk_25       (i_clk_25),
    .i_rst_n        (i_rst_n),
    .i_lyr_drawing  (i_lyr_drawing),
    .i_lyr_pix      (i_lyr_pix),
    .i_lyr_colr     (i_lyr_colr),
    .i_hsync        (i_hsync),
    .i_vsync        (i_vsync),
    .i_de           (i_de),
    .i_frame        (i_frame),
    .i_fade_out_req (i_fade_out_req),
    .i_fade_in_req  (i_fade_in_req),
    .o_r            (o_r),
    .o_g            (o_g),
    .o_b            (o_b),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_blank_n      (o_blank_n),
    .o_fade_busy    (o_fade_busy),
    .o_fade_done    (o_fade_done)
  );

  always @(negedge i_clk_25) if (i_rst_n && o_fade_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk_25);
    #1;
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, o_r, o_g, o_b}, {8'h00, exp});
  endtask

  task automatic set_layer(input int k, input logic draw, input logic [3:0] pix,
                           input logic [11:0] colr);
    i_lyr_drawing[k]      = draw;
    i_lyr_pix[4*k +: 4]   = pix;
    i_lyr_colr[12*k +: 12] = colr;
  endtask

  task automatic frame_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      i_frame = 1'b1;
      step(1);
      i_frame = 1'b0;
      step(3);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_lyr_drawing = '0; i_lyr_pix = '0; i_lyr_colr = '0;
    i_hsync = 1'b1; i_vsync = 1'b1; i_de = 1'b1; i_frame = 1'b0;
    i_fade_out_req = 1'b0; i_fade_in_req = 1'b0;
    step(3);

    check_rgb("rst_rgb", 24'h000000);
    check("rst_hsync", o_hsync, 1);
    check("rst_vsync", o_vsync, 1);
    check("rst_blank_n", o_blank_n, 0);
    check("rst_busy", o_fade_busy, 0);
    check("rst_done", o_fade_done, 0);

    i_rst_n = 1'b1;
    step(6);
    check("de_settled", o_blank_n, 1);

    // Layer priority and two-cycle latency
    set_layer(2, 1'b1, 4'd3, 12'hF80);
    step(1);
    check_rgb("lat_n1", 24'h000000);
    step(1);
    check_rgb("lyr2_only", 24'hFF8800);
    set_layer(0, 1'b1, 4'd0, 12'h1C9);
    set_layer(1, 1'b1, 4'd5, 12'h3A5);
    step(2);
    check_rgb("lyr0_trans", 24'h33AA55);
    set_layer(0, 1'b1, 4'd2, 12'h1C9);
    step(2);
    check_rgb("lyr0_wins", 24'h11CC99);
    set_layer(0, 1'b0, 4'd2, 12'h1C9);
    step(2);
    check_rgb("lyr0_idle", 24'h33AA55);
    i_lyr_drawing = '0;
    step(2);
    check_rgb("bg_fill", 24'h000000);

    // Sync delay of SYNC_DLY+2 = 4 cycles
    i_hsync = 1'b0;
    step(3);
    check("hs_n3", o_hsync, 1);
    step(1);
    check("hs_n4", o_hsync, 0);
    i_hsync = 1'b1;
    i_vsync = 1'b0;
    step(4);
    check("hs_back", o_hsync, 1);
    check("vs_n4", o_vsync, 0);
    i_vsync = 1'b1;

    // Blank forcing
    set_layer(0, 1'b1, 4'd1, 12'hFFF);
    step(6);
    check_rgb("white", 24'hFFFFFF);
    i_de = 1'b0;
    step(5);
    for (int i = 0; i < 4; i++) begin
      check_rgb("blank_rgb", 24'h000000);
      check("blank_n", o_blank_n, 0);
      step(1);
    end
    i_de = 1'b1;
    step(5);
    check_rgb("unblank", 24'hFFFFFF);
    check("unblank_n", o_blank_n, 1);

    // Full fade out: one level per two frames
    i_fade_out_req = 1'b1;
    step(1);
    i_fade_out_req = 1'b0;
    check("fo_busy", o_fade_busy, 1);
    frame_pulse(1);
    check_rgb("fo_f1", 24'hFFFFFF);
    frame_pulse(1);
    check_rgb("fo_f2_L15", 24'hEFEFEF);
    frame_pulse(28);
    check_rgb("fo_f30_L1", 24'h0F0F0F);
    frame_pulse(1);
    check_rgb("fo_f31_L1", 24'h0F0F0F);
    check("fo_no_done_yet", done_cnt, 0);
    frame_pulse(1);
    check_rgb("fo_dark", 24'h000000);
    check("fo_idle", o_fade_busy, 0);
    check("fo_done_once", done_cnt, 1);

    // Out-request in DARK is ignored; in-request starts fade in
    i_fade_out_req = 1'b1;
    step(1);
    i_fade_out_req = 1'b0;
    step(2);
    check("dark_ignore", o_fade_busy, 0);
    i_fade_in_req = 1'b1;
    step(1);
    i_fade_in_req = 1'b0;
    frame_pulse(2);
    check_rgb("fi_L1", 24'h0F0F0F);
    check("fi_busy", o_fade_busy, 1);

    i_rst_n = 1'b0;
    step(2);
    i_rst_n = 1'b1;
    step(6);
    check_rgb("rst_bright", 24'hFFFFFF);

    // Both requests plus a frame pulse in BRIGHT: fade out, no step this cycle
    i_fade_out_req = 1'b1; i_fade_in_req = 1'b1; i_frame = 1'b1;
    step(1);
    i_fade_out_req = 1'b0; i_fade_in_req = 1'b0; i_frame = 1'b0;
    step(3);
    check("both_busy", o_fade_busy, 1);
    frame_pulse(1);
    check_rgb("both_f1", 24'hFFFFFF);
    frame_pulse(1);
    check_rgb("both_L15", 24'hEFEFEF);
    frame_pulse(10);
    check_rgb("fo_L10", 24'h9F9F9F);

    // Reverse at L=10
    i_fade_in_req = 1'b1;
    step(1);
    i_fade_in_req = 1'b0;
    frame_pulse(1);
    check_rgb("rev_f1", 24'h9F9F9F);
    frame_pulse(1);
    check_rgb("rev_L11", 24'hAFAFAF);
    i_fade_out_req = 1'b1; i_fade_in_req = 1'b1;
    step(1);
    i_fade_out_req = 1'b0; i_fade_in_req = 1'b0;
    frame_pulse(2);
    check_rgb("rev2_L10", 24'h9F9F9F);
    frame_pulse(6);
    check_rgb("fo_L7", 24'h6F6F6F);

    // Reset mid-fade
    i_rst_n = 1'b0;
    step(1);
    check_rgb("midrst_rgb", 24'h000000);
    check("midrst_busy", o_fade_busy, 0);
    check("midrst_blank", o_blank_n, 0);
    i_rst_n = 1'b1;
    step(6);
    check_rgb("midrst_L16", 24'hFFFFFF);
    frame_pulse(2);
    check_rgb("midrst_hold", 24'hFFFFFF);
    check("midrst_busy2", o_fade_busy, 0);
    check("midrst_no_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_mixer.md
# layer_mixer

Final pixel stage between the sprite/item renderers and the DE2-115 VGA DAC. Takes per-layer palette colours from up to `LAYERS` sprite instances, resolves priority and transparency, and fills uncovered pixels with a background colour. Applies a frame-synchronous global fade, and delays the timing-generator syncs so that RGB, sync and blank leave aligned on registered outputs.

## Interface

Parameters:
- `LAYERS`, 4, number of sprite layers; layer 0 has highest priority.
- `TRANS_IDX`, 0, palette index treated as transparent.
- `SYNC_DLY`, 2, cycles the sprite colour outputs lag the timing generator.
- `FADE_FRAMES`, 2, frames per brightness step.
- `BG_COLR`, 12'h000, background colour as 4:4:4 RGB.

Ports (`LYR_*` buses: layer k occupies slice k):
- `i_clk_25`  in  1  25 MHz pixel clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_lyr_drawing`  in  LAYERS  per-layer drawing flag (sprite `drawing_r`).
- `i_lyr_pix`  in  4*LAYERS  per-layer palette index.
- `i_lyr_colr`  in  12*LAYERS  per-layer 4:4:4 colour.
- `i_hsync`, `i_vsync`, `i_de`  in  1 each  syncs and data-enable, undelayed from the timing generator.
- `i_frame`  in  1  one-cycle pulse per frame, during vertical blank.
- `i_fade_out_req`, `i_fade_in_req`  in  1 each  one-cycle fade requests.
- `o_r`, `o_g`, `o_b`  out  8 each  DAC colour.
- `o_hsync`, `o_vsync`, `o_blank_n`  out  1 each  aligned syncs and blank.
- `o_fade_busy`  out  1  high while fading.
- `o_fade_done`  out  1  one-cycle pulse when a fade completes.

## Operation

**Layer select**
- A layer is opaque when `drawing` is 1 and `pix != TRANS_IDX`.
- The lowest-index opaque layer wins.
- If no layer is opaque, `BG_COLR` is used.

**Expansion**
- Each 4-bit channel c becomes 8 bits as {c,c}, i.e. c*17.

**Brightness**
- Level L ranges over 0..16 (5 bits).
- out = (c8 * L) >> 4, computed with a 13-bit intermediate. The result for L=16 must be clamped/handled so that it equals c8 exactly.
- L=0 gives black.

**Blank**
- When the delayed `de` is 0, RGB is forced to 0 and `o_blank_n` is 0.

**Sync path**
- `hsync`, `vsync` and `de` pass through a shift register of `SYNC_DLY`+2 stages.
- The extra 2 stages match the colour pipeline.

**Fade FSM**
- States: BRIGHT (L=16), FADE_OUT, DARK (L=0), FADE_IN.
- BRIGHT → FADE_OUT on `i_fade_out_req`.
- DARK → FADE_IN on `i_fade_in_req`.
- FADE_OUT + `i_fade_in_req` → FADE_IN, continuing from the current L.
- FADE_IN + `i_fade_out_req` → FADE_OUT, continuing from the current L.
- Stepping: a frame counter (0..FADE_FRAMES-1) counts `i_frame` pulses while fading. When it wraps, L steps by ±1.
- FADE_OUT reaching L=0 → DARK, with `o_fade_done` pulsing for 1 cycle.
- FADE_IN reaching L=16 → BRIGHT, with `o_fade_done` pulsing for 1 cycle.
- The frame counter clears on every state entry.
- Requests that do not match a transition are ignored (e.g. out-req in DARK, in-req in BRIGHT).
- Both requests in the same cycle: the out-request wins.
- `o_fade_busy` = state is FADE_OUT or FADE_IN.

## Timing

**Latency**
- Stage 1 (registered): winner colour selection and delayed `de`.
- Stage 2 (registered): expansion, brightness scale, blank force, outputs.
- Layer inputs at cycle n appear on `o_r`/`o_g`/`o_b` at n+2.
- Syncs at cycle n appear at n+SYNC_DLY+2.

**Fade timing**
- L changes only in the cycle after an `i_frame` pulse, so no mid-frame brightness change occurs.
- A request and an `i_frame` pulse in the same cycle: the state transition occurs and the frame counter clears. No step is taken that cycle.

**Reset values**
- `o_r`, `o_g`, `o_b` = 0.
- `o_hsync` = 1, `o_vsync` = 1 (VGA syncs are active-low); the sync delay line resets to 1s.
- `o_blank_n` = 0; `de` delay stages reset to 0.
- FSM = BRIGHT, L = 16, frame counter = 0.
- `o_fade_busy` = 0, `o_fade_done` = 0.

**Reset mid-fade**
- Returns immediately to BRIGHT, L=16.
- No `o_fade_done` pulse.

## Structure

- Package `mixer_pkg`:
  - `colr12_t` (4:4:4 packed struct) and `rgb24_t`.
  - `fade_state_t` enum.
  - constant `L_MAX` = 16.
  - function `expand4to8`.
- Sub-module `fade_ctrl`: contains the FSM, frame counter and level register. Outputs L, busy and done.
- The mixer top holds the priority select, the colour pipeline and the sync delay line.

## Test plan

- LAYERS=4, layer 2 drawing with colour 12'hF80 and pix=3, others idle → two cycles later RGB = FF/88/00.
- Layers 0 and 1 both drawing, layer 0 pix=TRANS_IDX → layer 1 colour output. With nothing opaque → `BG_COLR` output.
- Toggle `i_hsync` at cycle 10 with SYNC_DLY=2 → `o_hsync` toggles at cycle 14. With `i_de`=0 → RGB=0 and `o_blank_n`=0 for the whole blank interval.
- Constant colour 12'hFFF, `i_fade_out_req`, FADE_FRAMES=2 → L drops by 1 every 2 frames. After 32 frames RGB=0, state DARK, one `o_fade_done` pulse.
- FADE_OUT at L=10 with `i_fade_in_req` → L rises from 10. Simultaneous out/in requests in BRIGHT → FADE_OUT.
- Assert reset at L=7 → outputs 0, L=16 after release, no `o_fade_done` pulse.
